// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared constants, FSM encoding and helpers for the quadrature decoder
package quad_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1
  } state_t;

  // Priming must outlast the synchroniser and one full filter window.
  function automatic int prime_len(input int sync_stages, input int filt_len);
    return sync_stages + filt_len;
  endfunction

  // Next AB code in the up direction (A leads B): 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] up_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// rtl/sync_glitch_filter.sv - per-channel synchroniser plus persistence glitch filter
module sync_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  input  logic prime,
  output logic q_filt
);

  logic [SYNC_STAGES-1:0] sync;
  logic [3:0]             cnt;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  // Plain flop chain; nothing may sit between the stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_in};
    end
  end

  // Accept a new level only after it has differed for FILT_LEN consecutive cycles;
  // while priming, follow the synchronised level directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      q_filt <= 1'b0;
    end else if (prime) begin
      cnt    <= '0;
      q_filt <= sync_out;
    end else if (sync_out != q_filt) begin
      if (cnt == 4'(FILT_LEN - 1)) begin
        cnt    <= '0;
        q_filt <= sync_out;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - 4x quadrature decoder producing step/dir/err for a position counter
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic dir,
  output logic err
);

  localparam int PRIME_LEN = prime_len(SYNC_STAGES, FILT_LEN);

  state_t     state;
  logic [4:0] prime_cnt;
  logic [1:0] prev_ab;
  logic [1:0] cur_ab;
  logic       a_filt;
  logic       b_filt;
  logic       prime;
  logic       is_up;
  logic       is_down;
  logic       is_err;

  assign prime = (state == PRIME);

  sync_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_a (
    .clk   (clk),
    .rst   (rst),
    .d_in  (a_in),
    .prime (prime),
    .q_filt(a_filt)
  );

  sync_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filt_b (
    .clk   (clk),
    .rst   (rst),
    .d_in  (b_in),
    .prime (prime),
    .q_filt(b_filt)
  );

  assign cur_ab  = {a_filt, b_filt};
  assign is_up   = (cur_ab == up_next(prev_ab));
  assign is_down = (prev_ab == up_next(cur_ab));
  assign is_err  = ((cur_ab ^ prev_ab) == 2'b11);

  // Prime/run sequencing and registered decode; prev_ab tracks every cycle so
  // priming and disabled periods never leave a backlog transition behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PRIME;
      prime_cnt <= '0;
      prev_ab   <= 2'b00;
      step      <= 1'b0;
      err       <= 1'b0;
      dir       <= DIR_UP;
    end else begin
      prev_ab <= cur_ab;
      step    <= 1'b0;
      err     <= 1'b0;
      case (state)
        PRIME: begin
          if (prime_cnt == 5'(PRIME_LEN - 1)) begin
            state <= RUN;
          end else begin
            prime_cnt <= prime_cnt + 5'd1;
          end
        end
        RUN: begin
          if (en) begin
            if (is_up) begin
              step <= 1'b1;
              dir  <= DIR_UP;
            end else if (is_down) begin
              step <= 1'b1;
              dir  <= DIR_DOWN;
            end else if (is_err) begin
              err <= 1'b1;
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - scoreboard bench for quadrature_decoder
module tb_quadrature_decoder;

  logic clk;
  logic rst;
  logic en;
  logic a_in;
  logic b_in;
  logic step;
  logic dir;
  logic err;

  typedef struct {
    bit is_err;
    bit dir;
    int cyc;
  } ev_t;

  ev_t        q[$];
  ev_t        e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] pos;
  logic       pos_clr;

  quadrature_decoder #(
    .SYNC_STAGES(2),
    .FILT_LEN   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a_in(a_in),
    .b_in(b_in),
    .step(step),
    .dir (dir),
    .err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chained 4-bit up/down counter fed by step/dir.
  always @(posedge clk) begin
    if (pos_clr) pos <= 4'd0;
    else if (step) pos <= dir ? pos + 4'd1 : pos - 4'd1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every step or err pulse must match the next expected event.
  always @(negedge clk) begin
    if (step || err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got step=%0b err=%0b dir=%0b at cycle %0d, required no event",
                 step, err, dir, cyc);
      end else begin
        e = q.pop_front();
        check("event_err", int'(err), int'(e.is_err));
        check("event_step", int'(step), int'(!e.is_err));
        check("event_dir", int'(dir), int'(e.dir));
        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive a new AB code, expecting one event 7 edges later, then hold 10 cycles.
  task automatic step_to(input logic [1:0] ab, input bit is_e, input bit d);
    @(negedge clk);
    q.push_back('{is_e, d, cyc + 7});
    a_in = ab[1];
    b_in = ab[0];
    repeat (10) @(negedge clk);
  endtask

  task automatic drive_quiet(input logic [1:0] ab);
    @(negedge clk);
    a_in = ab[1];
    b_in = ab[0];
    repeat (10) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b1; a_in = 1'b1; b_in = 1'b1; pos_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_step", int'(step), 0);
    check("reset_dir", int'(dir), 1);
    check("reset_err", int'(err), 0);

    // Release with 11 idle: priming must swallow it.
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle11_dir", int'(dir), 1);
    check("idle11_step", int'(step), 0);
    check("idle11_err", int'(err), 0);

    // 11 -> 00 on both channels together is a double-bit change.
    step_to(2'b00, 1'b1, 1'b1);
    drain("drain_to00");
    @(negedge clk); pos_clr = 1'b1;
    @(negedge clk); pos_clr = 1'b0;

    // Up sequence.
    step_to(2'b10, 1'b0, 1'b1);
    step_to(2'b11, 1'b0, 1'b1);
    step_to(2'b01, 1'b0, 1'b1);
    step_to(2'b00, 1'b0, 1'b1);
    drain("drain_up");
    check("pos_after_up", int'(pos), 4);
    check("dir_after_up", int'(dir), 1);

    // Down sequence, twice.
    for (int r = 0; r < 2; r++) begin
      step_to(2'b01, 1'b0, 1'b0);
      step_to(2'b11, 1'b0, 1'b0);
      step_to(2'b10, 1'b0, 1'b0);
      step_to(2'b00, 1'b0, 1'b0);
      drain("drain_down");
      check("pos_after_down", int'(pos), (r == 0) ? 0 : 12);
    end
    check("dir_after_down", int'(dir), 0);

    // 3-cycle glitch must vanish.
    @(negedge clk); a_in = 1'b1;
    repeat (3) @(negedge clk); a_in = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch3_dir", int'(dir), 0);

    // 4-cycle pulse is accepted: up then down.
    @(negedge clk);
    q.push_back('{1'b0, 1'b1, cyc + 7});
    q.push_back('{1'b0, 1'b0, cyc + 11});
    a_in = 1'b1;
    repeat (4) @(negedge clk); a_in = 1'b0;
    repeat (15) @(negedge clk);
    drain("drain_pulse4");

    // Simultaneous change -> err with dir held, then legal up steps.
    step_to(2'b11, 1'b1, 1'b0);
    step_to(2'b01, 1'b0, 1'b1);
    step_to(2'b00, 1'b0, 1'b1);
    drain("drain_err");

    // Disabled motion emits nothing, and no backlog on re-enable.
    @(negedge clk); en = 1'b0;
    drive_quiet(2'b10);
    drive_quiet(2'b11);
    @(negedge clk); en = 1'b1;
    repeat (2) @(negedge clk);
    step_to(2'b01, 1'b0, 1'b1);
    check("dir_after_reenable", int'(dir), 1);
    step_to(2'b11, 1'b0, 1'b0);
    drain("drain_en");
    check("dir_before_rst", int'(dir), 0);

    // Reset mid-motion: asynchronous return, pending step discarded.
    @(negedge clk);
    a_in = 1'b1; b_in = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dir", int'(dir), 1);
    check("async_rst_step", int'(step), 0);
    check("async_rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_dir", int'(dir), 1);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
- Front-end stage feeding up_down_counter.
- Takes raw asynchronous quadrature inputs A/B from an encoder, synchronises and glitch-filters them, and decodes Gray transitions.
- Produces a one-cycle `step` pulse and a held `dir` level, which drive the counter's `en` and `up_down` directly.
- Illegal transitions are flagged on `err` rather than counted.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (legal range 2-4).
- FILT_LEN, 4, consecutive cycles a synchronised level must persist before it is accepted (legal range 1-15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  step enable; when 0, `step` and `err` are suppressed but position tracking continues.
- a_in  input  1  raw encoder channel A, asynchronous to clk.
- b_in  input  1  raw encoder channel B, asynchronous to clk.
- step  output  1  one-cycle pulse per accepted legal transition; connects to counter `en`.
- dir  output  1  1 = up, 0 = down; connects to counter `up_down`.
- err  output  1  one-cycle pulse on an illegal (double-bit) transition.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchroniser flops, filter counters and filtered levels go to 0.
  - prev_ab = 00, FSM = PRIME, prime counter = 0.
  - Outputs: step=0, dir=1, err=0.
- Synchroniser: SYNC_STAGES flops per channel, no logic between them.
- Filter, per channel:
  - A counter increments while the synchronised level differs from the filtered level.
  - It clears to 0 whenever the two agree.
  - When the counter reaches FILT_LEN-1 and they still differ, the filtered level takes the synchronised value on the next edge and the counter clears.
  - A pulse shorter than FILT_LEN cycles never reaches the filtered level.
- Decoder compares filtered AB against prev_ab every cycle and updates prev_ab to filtered AB every cycle.
  - Up sequence (AB): 00→10→11→01→00. A leads B.
  - Down sequence is the reverse.
  - Same value: no action.
  - Up or down neighbour: step=1 for one cycle and dir updated (1 up, 0 down) in the same cycle. dir holds until the next legal step.
  - Both bits changed: err=1 for one cycle, no step, dir unchanged, prev_ab still updated (resync).
  - 4x decoding: every edge of A and of B is one step.
- Latency: a raw edge stable before clock edge k produces step high in the cycle after edge k+SYNC_STAGES+FILT_LEN. With defaults this is 7 edges.
- FSM states:
  - PRIME: entered on reset. Lasts SYNC_STAGES+FILT_LEN cycles. Filtered levels load the synchronised value directly and prev_ab tracks them. step and err are held 0, so a non-00 idle position at reset release never produces err or step. Then go to RUN.
  - RUN: normal decode. Left only by reset.
- en=0: step and err forced to 0, dir not updated, prev_ab still tracks. Re-enabling therefore never emits a backlog step.
- Simultaneous A and B filter acceptance in the same cycle is treated as a double-bit change → err.
- Reset mid-motion: outputs return to reset values immediately. Decoding restarts via PRIME and no stale step is emitted.
- Maximum legal input edge rate: one edge per FILT_LEN+1 cycles per channel. Faster edges are filtered out, not reported.

Decomposition:
- Shared package quad_pkg holds:
  - DIR_UP=1'b1, DIR_DOWN=1'b0.
  - 2-bit FSM encoding PRIME=0, RUN=1.
  - Prime-length constant function of SYNC_STAGES and FILT_LEN.
- One sub-module, sync_glitch_filter:
  - Parameters SYNC_STAGES, FILT_LEN.
  - Ports clk, rst, d_in, q_filt, plus a prime input forcing pass-through.
  - Instantiated once per channel.
- Top level holds the decode logic and the FSM.

Test Plan:
- Reset with a_in=b_in=1 held, release rst, wait 20 cycles → step=0 and err=0 throughout, dir=1.
- From 00, drive 10,11,01,00, each held 10 cycles, en=1 → exactly 4 step pulses, each 1 cycle wide, dir=1. First pulse arrives 7 edges after a_in rises. Chained up_down_counter (N=4) reads 0100.
- From 00, drive 01,11,10,00 → 4 steps, dir=0 from the first step onward. Counter goes 0100→0000, then a further 4 steps wrap it to 1100.
- 3-cycle glitch on a_in (FILT_LEN=4) → no step, no err. A 4-cycle pulse → one up step followed by one down step.
- From 00, drive a_in and b_in to 11 on the same cycle → single err pulse, no step, dir unchanged. Subsequent 11→01 → one up step.
- en=0 while driving 10,11 → no step. en=1, then drive 01 → one step, dir=1. Assert rst mid-sequence → step=0 and dir=1 asynchronously, and no output until PRIME completes.
